// File: rtl/yarb4_ctrl.sv
// Four-requester round-robin arbiter feeding a single registered output slot.
// Grant is combinational in the request cycle; the winner's word lands in z on the next edge.
module yarb4_ctrl #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
   input  logic [SIZE-1:0] a0,
   input  logic [SIZE-1:0] a1,
   input  logic [SIZE-1:0] a2,
   input  logic [SIZE-1:0] a3,
   output logic [3:0]      gnt,
   output logic [1:0]      sel,
   output logic [SIZE-1:0] z,
   output logic            zValid,
   input  logic            zReady,
   output logic            stall
);

   typedef enum logic [1:0] {IDLE, BUSY, STALL} state_t;

   state_t          state;
   state_t          nextState;
   logic [1:0]      ptr;
   logic [1:0]      winner;
   logic            slotFree;
   logic            doGrant;
   logic [SIZE-1:0] winWord;

   // First requester found scanning ptr+1 .. ptr+4 (mod 4); ptr+4 wraps back onto ptr itself.
   function automatic logic [1:0] pickWinner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = p;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      slotFree  = (state == IDLE) || zReady;
      doGrant   = !rst && slotFree && (|req);
      winner    = pickWinner(req, ptr);
      gnt       = doGrant ? (4'b0001 << winner) : 4'b0000;
      case (winner)
         2'd0:    winWord = a0;
         2'd1:    winWord = a1;
         2'd2:    winWord = a2;
         default: winWord = a3;
      endcase
      nextState = state;
      if (doGrant)
         nextState = BUSY;
      else if (state != IDLE)
         nextState = zReady ? IDLE : STALL;
   end

   // A grant always refills the slot, so an accept plus new grant costs no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         z     <= '0;
         sel   <= 2'd0;
         ptr   <= 2'd3;
      end else begin
         state <= nextState;
         if (doGrant) begin
            z   <= winWord;
            sel <= winner;
            ptr <= winner;
         end
      end
   end

   assign zValid = (state != IDLE);
   assign stall  = (state == STALL);

endmodule

// File: tb/tb_yarb4_ctrl.sv
// Scenario bench for yarb4_ctrl: expected words/indices are queued at grant time
// and popped after the loading edge.
module tb_yarb4_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] a0, a1, a2, a3;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [31:0] z;
   logic        zValid;
   logic        zReady;
   logic        stall;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  idx;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   nChecks = 0;
   int   nFails  = 0;

   yarb4_ctrl #(.SIZE(32)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3),
      .gnt(gnt), .sel(sel), .z(z), .zValid(zValid), .zReady(zReady), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; req = 4'b0000; zReady = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; zReady = 1'b1;
      #1;
      nChecks++; if (gnt !== 4'b0000) begin nFails++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
      tick();
      nChecks++; if (zValid !== 1'b0) begin nFails++; $display("FAIL reset_zValid: got %b expected 0", zValid); end
      nChecks++; if (stall !== 1'b0) begin nFails++; $display("FAIL reset_stall: got %b expected 0", stall); end
      nChecks++; if (z !== 32'h0) begin nFails++; $display("FAIL reset_z: got %h expected %h", z, 32'h0); end
      nChecks++; if (sel !== 2'd0) begin nFails++; $display("FAIL reset_sel: got %0d expected 0", sel); end
      rst = 1'b0;
      #1;
      nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL reset_first_gnt: got %b expected %b", gnt, 4'b0001); end
      sbq.push_back('{word: a0, idx: 2'd0});
      tick();
      req = 4'b0000;
      e = sbq.pop_front();
      nChecks++; if (z !== e.word) begin nFails++; $display("FAIL reset_first_z: got %h expected %h", z, e.word); end
      nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL reset_first_sel: got %0d expected %0d", sel, e.idx); end
   endtask

   task automatic test_single();
      doReset();
      a2 = 32'hDEADBEEF; req = 4'b0100;
      #1;
      nChecks++; if (gnt !== 4'b0100) begin nFails++; $display("FAIL single_gnt: got %b expected %b", gnt, 4'b0100); end
      sbq.push_back('{word: 32'hDEADBEEF, idx: 2'd2});
      tick();
      req = 4'b0000;
      e = sbq.pop_front();
      nChecks++; if (z !== e.word) begin nFails++; $display("FAIL single_z: got %h expected %h", z, e.word); end
      nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL single_sel: got %0d expected %0d", sel, e.idx); end
      nChecks++; if (zValid !== 1'b1) begin nFails++; $display("FAIL single_zValid: got %b expected 1", zValid); end
   endtask

   task automatic test_fairness();
      logic [1:0]  order [5];
      logic [31:0] words [4];
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
      doReset();
      a0 = words[0]; a1 = words[1]; a2 = words[2]; a3 = words[3];
      req = 4'b1111; zReady = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         nChecks++; if (gnt !== (4'b0001 << order[k])) begin nFails++; $display("FAIL fair_gnt%0d: got %b expected %b", k, gnt, 4'b0001 << order[k]); end
         sbq.push_back('{word: words[order[k]], idx: order[k]});
         tick();
         e = sbq.pop_front();
         nChecks++; if (z !== e.word) begin nFails++; $display("FAIL fair_z%0d: got %h expected %h", k, z, e.word); end
         nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL fair_sel%0d: got %0d expected %0d", k, sel, e.idx); end
         nChecks++; if (zValid !== 1'b1) begin nFails++; $display("FAIL fair_zValid%0d: got %b expected 1", k, zValid); end
      end
      req = 4'b0000;
   endtask

   task automatic test_stall();
      doReset();
      a0 = 32'hA0A0_0000; a1 = 32'hB1B1_0001;
      req = 4'b0001; zReady = 1'b1;
      #1;
      nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL stall_load_gnt: got %b expected %b", gnt, 4'b0001); end
      sbq.push_back('{word: 32'hA0A0_0000, idx: 2'd0});
      tick();
      e = sbq.pop_front();
      nChecks++; if (z !== e.word) begin nFails++; $display("FAIL stall_load_z: got %h expected %h", z, e.word); end
      req = 4'b0010; zReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         nChecks++; if (gnt !== 4'b0000) begin nFails++; $display("FAIL stall_gnt%0d: got %b expected %b", k, gnt, 4'b0000); end
         tick();
         nChecks++; if (stall !== 1'b1) begin nFails++; $display("FAIL stall_flag%0d: got %b expected 1", k, stall); end
         nChecks++; if (z !== 32'hA0A0_0000) begin nFails++; $display("FAIL stall_z%0d: got %h expected %h", k, z, 32'hA0A0_0000); end
         nChecks++; if (sel !== 2'd0) begin nFails++; $display("FAIL stall_sel%0d: got %0d expected 0", k, sel); end
      end
      zReady = 1'b1;
      #1;
      nChecks++; if (gnt !== 4'b0010) begin nFails++; $display("FAIL stall_release_gnt: got %b expected %b", gnt, 4'b0010); end
      sbq.push_back('{word: 32'hB1B1_0001, idx: 2'd1});
      tick();
      req = 4'b0000;
      e = sbq.pop_front();
      nChecks++; if (z !== e.word) begin nFails++; $display("FAIL stall_release_z: got %h expected %h", z, e.word); end
      nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL stall_release_sel: got %0d expected %0d", sel, e.idx); end
      nChecks++; if (stall !== 1'b0) begin nFails++; $display("FAIL stall_release_flag: got %b expected 0", stall); end
   endtask

   task automatic test_wrap();
      logic [1:0] order [3];
      order = '{2'd0, 2'd3, 2'd0};
      doReset();
      a0 = 32'h0000_C0DE; a3 = 32'h3333_C0DE;
      req = 4'b1001; zReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         nChecks++; if (gnt !== (4'b0001 << order[k])) begin nFails++; $display("FAIL wrap_gnt%0d: got %b expected %b", k, gnt, 4'b0001 << order[k]); end
         sbq.push_back('{word: (order[k] == 2'd0) ? 32'h0000_C0DE : 32'h3333_C0DE, idx: order[k]});
         tick();
         e = sbq.pop_front();
         nChecks++; if (z !== e.word) begin nFails++; $display("FAIL wrap_z%0d: got %h expected %h", k, z, e.word); end
         nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL wrap_sel%0d: got %0d expected %0d", k, sel, e.idx); end
      end
      req = 4'b0000;
   endtask

   task automatic test_drain();
      doReset();
      a1 = 32'h5555_AAAA; req = 4'b0010; zReady = 1'b1;
      tick();
      req = 4'b0000;
      nChecks++; if (zValid !== 1'b1) begin nFails++; $display("FAIL drain_busy: got %b expected 1", zValid); end
      #1;
      nChecks++; if (gnt !== 4'b0000) begin nFails++; $display("FAIL drain_gnt: got %b expected %b", gnt, 4'b0000); end
      tick();
      nChecks++; if (zValid !== 1'b0) begin nFails++; $display("FAIL drain_zValid: got %b expected 0", zValid); end
      nChecks++; if (stall !== 1'b0) begin nFails++; $display("FAIL drain_stall: got %b expected 0", stall); end
      tick();
      nChecks++; if (zValid !== 1'b0) begin nFails++; $display("FAIL drain_idle_hold: got %b expected 0", zValid); end
   endtask

   task automatic test_reset_mid_stall();
      doReset();
      a0 = 32'h0F0F_0F0F; a2 = 32'h7777_2222;
      req = 4'b0100; zReady = 1'b1;
      tick();
      req = 4'b0000; zReady = 1'b0;
      tick();
      nChecks++; if (stall !== 1'b1) begin nFails++; $display("FAIL midrst_stall: got %b expected 1", stall); end
      rst = 1'b1; req = 4'b1111;
      #1;
      nChecks++; if (gnt !== 4'b0000) begin nFails++; $display("FAIL midrst_gnt_in_rst: got %b expected %b", gnt, 4'b0000); end
      tick();
      rst = 1'b0;
      nChecks++; if (zValid !== 1'b0) begin nFails++; $display("FAIL midrst_zValid: got %b expected 0", zValid); end
      nChecks++; if (z !== 32'h0) begin nFails++; $display("FAIL midrst_z: got %h expected %h", z, 32'h0); end
      nChecks++; if (sel !== 2'd0) begin nFails++; $display("FAIL midrst_sel: got %0d expected 0", sel); end
      nChecks++; if (stall !== 1'b0) begin nFails++; $display("FAIL midrst_stall_clr: got %b expected 0", stall); end
      zReady = 1'b1;
      #1;
      nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL midrst_first_gnt: got %b expected %b", gnt, 4'b0001); end
      sbq.push_back('{word: 32'h0F0F_0F0F, idx: 2'd0});
      tick();
      req = 4'b0000;
      e = sbq.pop_front();
      nChecks++; if (z !== e.word) begin nFails++; $display("FAIL midrst_z_after: got %h expected %h", z, e.word); end
      nChecks++; if (sel !== e.idx) begin nFails++; $display("FAIL midrst_sel_after: got %0d expected %0d", sel, e.idx); end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; zReady = 1'b1;
      a0 = 32'h0000_00A0; a1 = 32'h0000_00A1; a2 = 32'h0000_00A2; a3 = 32'h0000_00A3;
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_wrap();
      test_drain();
      test_reset_mid_stall();
      nChecks++; if (sbq.size() !== 0) begin nFails++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sbq.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/yarb4_ctrl.md
YARB4_CTRL -- requirements
Module: yarb4_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 32, the width of each data word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: req[i] is asserted by requester i while it has a word pending.
REQ-005 SHALL have ports a0, a1, a2, a3, input, SIZE bits each: the data word of requester 0..3, held stable while the matching req bit is high.
REQ-006 SHALL have port gnt, output, 4 bits: a one-hot, single-cycle grant; requester i drops or advances its word after the clk edge on which gnt[i]=1.
REQ-007 SHALL have port sel, output, 2 bits: the registered index of the last granted requester, used as the 4-to-1 mux select.
REQ-008 SHALL have port z, output, SIZE bits: the registered output word.
REQ-009 SHALL have port zValid, output, 1 bit: z holds an unconsumed word.
REQ-010 SHALL have port zReady, input, 1 bit: the consumer accepts z on an edge where zValid=1 and zReady=1.
REQ-011 SHALL have port stall, output, 1 bit: high while the FSM is in STALL.

Function
REQ-012 SHALL implement a 3-state FSM with states IDLE (zValid=0), BUSY (zValid=1, first cycle after load or accept) and STALL (zValid=1, word held).
REQ-013 SHALL define slot-free as (state==IDLE) or zReady=1.
REQ-014 SHALL, when slot-free and |req, assert exactly one gnt bit combinationally in that cycle, load z with the winner's word at the next edge, set sel to the winner index and enter BUSY.
REQ-015 SHALL never assert gnt when not slot-free or when req=0.
REQ-016 SHALL choose the winner round-robin: scan indices ptr+1, ptr+2, ptr+3 and ptr+4 (mod 4) and grant the first with req set, where ptr is the index of the last grant.
REQ-017 SHALL update ptr only on a grant, setting it to the winner index; wrap 3 to 0 is modulo 4.
REQ-018 SHALL go from BUSY or STALL to IDLE when zReady=1 and req=0.
REQ-019 SHALL go from BUSY to STALL, and keep STALL, when zReady=0.
REQ-020 SHALL keep z, sel and ptr unchanged while in STALL.
REQ-021 SHALL, when zReady=1 and |req in the same cycle (back-to-back), complete the accept and the new grant on one edge with no bubble: zValid stays 1 and z takes the new word.
REQ-022 SHALL ignore changes on req bits that are not granted; there is no preemption and no partial transfer.
REQ-023 SHALL give a grant latency of 0 cycles (gnt in the request cycle when slot-free) and a data latency of 1 cycle (z valid after the next edge).
REQ-024 SHALL have the sustained throughput of one word per cycle while zReady=1 and req is non-zero.
REQ-025 SHALL ensure that with all four req bits held high, each requester is granted exactly once in any 4 consecutive grants.

Reset
REQ-026 SHALL, on an edge with rst=1, enter IDLE and drive zValid=0, stall=0, z=0, sel=0 and ptr=3, so that requester 0 has first priority.
REQ-027 SHALL drive gnt=0 during any cycle with rst=1, regardless of req.
REQ-028 SHALL discard any held word on a reset asserted mid-operation (BUSY or STALL), and SHALL NOT re-grant it without a new req.
REQ-029 SHALL honour a request present in the first cycle after rst deasserts in that same cycle.

Verification
REQ-030 The bench SHALL cover a single request: after reset, req=0100 and a2=32'hDEADBEEF -> gnt=0100 in that cycle; next cycle z=32'hDEADBEEF, sel=2, zValid=1.
REQ-031 The bench SHALL cover fairness: req=1111 held, zReady=1 -> grant order 0, 1, 2, 3, 0, with one grant per cycle and zValid continuously 1.
REQ-032 The bench SHALL cover a stall: a word loaded, then zReady=0 for 3 cycles with req=0010 -> stall=1, gnt=0000, z and sel unchanged; when zReady returns to 1 -> gnt=0010 and the new word loads at the next edge.
REQ-033 The bench SHALL cover wrap-around: ptr=3 and req=1001 -> requester 0 is granted; the next grant with req=1001 still held -> requester 3.
REQ-034 The bench SHALL cover the drain to IDLE: in BUSY with zReady=1 and req=0 -> next cycle zValid=0 and state IDLE.
REQ-035 The bench SHALL cover reset mid-stall: in STALL, pulse rst=1 for 1 cycle -> zValid=0, z=0, sel=0; with req=1111 afterwards -> first grant to requester 0.
